// File: rtl/dff_pipe_set_en_rst.sv
`default_nettype none
// ============================================================================
// Module   : dff_pipe_set_en_rst
// Brief    : WIDTH x DEPTH stall-able flop pipeline with per-stage valid,
//            global advance enable, stage-0 OR-set mask, flush (clr) and
//            per-stage tap outputs. Optional occupancy counter output 'occ'
//            is built when macro DFF_PIPE_OCCUPANCY_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module dff_pipe_set_en_rst #(
    parameter int               WIDTH       = 1,
    parameter int               DEPTH       = 2,
    parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{1'b0}}
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clr,
    input  logic                     en,
    input  logic [WIDTH-1:0]         d,
    input  logic                     vld_in,
    input  logic [WIDTH-1:0]         set_mask,
    output logic [WIDTH-1:0]         q,
    output logic                     q_vld,
    output logic [WIDTH*DEPTH-1:0]   taps,
    output logic [DEPTH-1:0]         taps_vld
`ifdef DFF_PIPE_OCCUPANCY_EN
    ,
    output logic [$clog2(DEPTH+1)-1:0] occ
`endif
);

    // Stage storage; index 0 is the entry stage, DEPTH-1 drives q.
    logic [DEPTH-1:0][WIDTH-1:0] stage_q;
    logic [DEPTH-1:0][WIDTH-1:0] stage_d;
    logic [DEPTH-1:0]            vld_q;
    logic [DEPTH-1:0]            vld_d;

    // Next-state: flush, shift on en, otherwise hold with set_mask OR-ed into stage 0.
    always_comb begin
        stage_d = stage_q;
        vld_d   = vld_q;
        if (clr) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_d[i] = RESET_VALUE;
            end
            vld_d = '0;
        end else if (en) begin
            stage_d[0] = d | set_mask;
            vld_d[0]   = vld_in;
            for (int i = 1; i < DEPTH; i++) begin
                stage_d[i] = stage_q[i-1];
                vld_d[i]   = vld_q[i-1];
            end
        end else begin
            // Set mask wins over a stall but leaves the valid bit alone.
            stage_d[0] = stage_q[0] | set_mask;
        end
    end

    // Stage and valid registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_q[i] <= RESET_VALUE;
            end
            vld_q <= '0;
        end else begin
            stage_q <= stage_d;
            vld_q   <= vld_d;
        end
    end

    // Flatten the stages onto the tap bus, stage i at [i*WIDTH +: WIDTH].
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_taps
        assign taps[gi*WIDTH +: WIDTH] = stage_q[gi];
    end

    assign taps_vld = vld_q;
    assign q        = stage_q[DEPTH-1];
    assign q_vld    = vld_q[DEPTH-1];

`ifdef DFF_PIPE_OCCUPANCY_EN
    localparam int OCC_W = $clog2(DEPTH+1);

    logic [OCC_W-1:0] occ_q;
    logic [OCC_W-1:0] occ_d;

    // Occupancy tracks entries in minus entries out; range 0..DEPTH never wraps.
    always_comb begin
        occ_d = occ_q;
        if (clr) begin
            occ_d = '0;
        end else if (en) begin
            occ_d = occ_q + OCC_W'(vld_in) - OCC_W'(vld_q[DEPTH-1]);
        end
    end

    // Occupancy register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            occ_q <= '0;
        end else begin
            occ_q <= occ_d;
        end
    end

    assign occ = occ_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_dff_pipe_set_en_rst.sv
`default_nettype none
// ============================================================================
// Module   : tb_dff_pipe_set_en_rst
// Brief    : Self-checking bench: directed vector table, DEPTH=1 corner
//            sequence and randomized traffic against a queue-based model.
//            Occupancy checks are compiled in with DFF_PIPE_OCCUPANCY_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dff_pipe_set_en_rst;

    localparam int         WIDTH = 8;
    localparam int         DEPTH = 3;
    localparam logic [7:0] RV    = 8'hA5;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Main DUT (8 x 3)
    logic        rst = 1'b0, clr = 1'b0, en = 1'b0, vld_in = 1'b0;
    logic [7:0]  d = '0, set_mask = '0;
    logic [7:0]  q;
    logic        q_vld;
    logic [23:0] taps;
    logic [2:0]  taps_vld;
`ifdef DFF_PIPE_OCCUPANCY_EN
    logic [1:0]  occ;
`endif

    dff_pipe_set_en_rst #(.WIDTH(WIDTH), .DEPTH(DEPTH), .RESET_VALUE(RV)) u_dut (
        .clk(clk), .rst(rst), .clr(clr), .en(en), .d(d), .vld_in(vld_in),
        .set_mask(set_mask), .q(q), .q_vld(q_vld), .taps(taps), .taps_vld(taps_vld)
`ifdef DFF_PIPE_OCCUPANCY_EN
        , .occ(occ)
`endif
    );

    // Degenerate DUT (1 x 1, reset value 1)
    logic rst1 = 1'b0, clr1 = 1'b0, en1 = 1'b0, d1 = 1'b0, vld1 = 1'b0, mask1 = 1'b0;
    logic q1, qv1;
    logic [0:0] taps1, tv1;
`ifdef DFF_PIPE_OCCUPANCY_EN
    logic [0:0] occ1;
`endif

    dff_pipe_set_en_rst #(.WIDTH(1), .DEPTH(1), .RESET_VALUE(1'b1)) u_dut1 (
        .clk(clk), .rst(rst1), .clr(clr1), .en(en1), .d(d1), .vld_in(vld1),
        .set_mask(mask1), .q(q1), .q_vld(qv1), .taps(taps1), .taps_vld(tv1)
`ifdef DFF_PIPE_OCCUPANCY_EN
        , .occ(occ1)
`endif
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a queue of {data, valid} entries, index 0 = entry stage.
    typedef struct { logic [7:0] data; logic v; } ent_t;
    ent_t mq[$];

    task automatic model_flush();
        mq.delete();
        for (int i = 0; i < DEPTH; i++) mq.push_back('{RV, 1'b0});
    endtask

    task automatic model_update();
        if (rst || clr) begin
            model_flush();
        end else if (en) begin
            mq.push_front('{d | set_mask, vld_in});
            void'(mq.pop_back());
        end else begin
            mq[0].data = mq[0].data | set_mask;
        end
    endtask

    function automatic logic [23:0] model_taps();
        logic [23:0] t;
        for (int i = 0; i < DEPTH; i++) t[i*8 +: 8] = mq[i].data;
        return t;
    endfunction

    function automatic logic [2:0] model_tv();
        logic [2:0] t;
        for (int i = 0; i < DEPTH; i++) t[i] = mq[i].v;
        return t;
    endfunction

    // One clock edge: model follows the inputs present at the edge; sample #1 later.
    task automatic tick();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic chk_model(input string tag);
        chk({tag, " q"},        64'(q),        64'(mq[DEPTH-1].data));
        chk({tag, " q_vld"},    64'(q_vld),    64'(mq[DEPTH-1].v));
        chk({tag, " taps"},     64'(taps),     64'(model_taps()));
        chk({tag, " taps_vld"}, 64'(taps_vld), 64'(model_tv()));
`ifdef DFF_PIPE_OCCUPANCY_EN
        chk({tag, " occ"},      64'(occ),      64'($countones(model_tv())));
`endif
    endtask

    typedef struct {
        logic        rst, clr, en;
        logic [7:0]  d;
        logic        vld;
        logic [7:0]  mask;
        logic [7:0]  eq;
        logic        eqv;
        logic [23:0] et;
        logic [2:0]  etv;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic r, input logic c, input logic e, input logic [7:0] dd,
                       input logic v, input logic [7:0] m, input logic [7:0] eq,
                       input logic eqv, input logic [23:0] et, input logic [2:0] etv);
        tbl.push_back('{r, c, e, dd, v, m, eq, eqv, et, etv});
    endtask

    initial begin
        model_flush();

        //   rst clr en d      v  mask   q      qv taps        tv
        // reset with traffic on the inputs
        add(1, 0, 1, 8'hFF, 1, 8'h00, 8'hA5, 0, 24'hA5A5A5, 3'b000);
        add(1, 0, 1, 8'hFF, 1, 8'h00, 8'hA5, 0, 24'hA5A5A5, 3'b000);
        // latency
        add(0, 0, 1, 8'h11, 1, 8'h00, 8'hA5, 0, 24'hA5A511, 3'b001);
        add(0, 0, 1, 8'h22, 1, 8'h00, 8'hA5, 0, 24'hA51122, 3'b011);
        add(0, 0, 1, 8'h33, 1, 8'h00, 8'h11, 1, 24'h112233, 3'b111);
        add(0, 0, 1, 8'h44, 1, 8'h00, 8'h22, 1, 24'h223344, 3'b111);
        add(0, 0, 1, 8'h55, 0, 8'h00, 8'h33, 1, 24'h334455, 3'b110);
        // refill, then clr flush of a full pipe
        add(0, 0, 1, 8'h66, 1, 8'h00, 8'h44, 1, 24'h445566, 3'b101);
        add(0, 0, 1, 8'h77, 1, 8'h00, 8'h55, 0, 24'h556677, 3'b011);
        add(0, 0, 1, 8'h88, 1, 8'h00, 8'h66, 1, 24'h667788, 3'b111);
        add(0, 1, 1, 8'hFF, 1, 8'hFF, 8'hA5, 0, 24'hA5A5A5, 3'b000);
        // stall: 11 in, four en=0 edges, then two en=1 edges
        add(0, 0, 1, 8'h11, 1, 8'h00, 8'hA5, 0, 24'hA5A511, 3'b001);
        add(0, 0, 0, 8'hEE, 1, 8'h00, 8'hA5, 0, 24'hA5A511, 3'b001);
        add(0, 0, 0, 8'hEE, 1, 8'h00, 8'hA5, 0, 24'hA5A511, 3'b001);
        add(0, 0, 0, 8'hEE, 1, 8'h00, 8'hA5, 0, 24'hA5A511, 3'b001);
        add(0, 0, 0, 8'hEE, 1, 8'h00, 8'hA5, 0, 24'hA5A511, 3'b001);
        add(0, 0, 1, 8'h22, 0, 8'h00, 8'hA5, 0, 24'hA51122, 3'b010);
        add(0, 0, 1, 8'h33, 0, 8'h00, 8'h11, 1, 24'h112233, 3'b100);
        // set override during stall, then during advance
        add(0, 0, 1, 8'h01, 1, 8'h00, 8'h22, 0, 24'h223301, 3'b001);
        add(0, 0, 0, 8'hFF, 0, 8'h80, 8'h22, 0, 24'h223381, 3'b001);
        add(0, 0, 1, 8'h02, 1, 8'h04, 8'h33, 0, 24'h338106, 3'b011);
        // fill, then rst+clr together
        add(0, 0, 1, 8'hAA, 1, 8'h00, 8'h81, 1, 24'h8106AA, 3'b111);
        add(1, 1, 1, 8'hFF, 1, 8'hFF, 8'hA5, 0, 24'hA5A5A5, 3'b000);

        for (int i = 0; i < tbl.size(); i++) begin
            rst = tbl[i].rst; clr = tbl[i].clr; en = tbl[i].en;
            d = tbl[i].d; vld_in = tbl[i].vld; set_mask = tbl[i].mask;
            tick();
            chk($sformatf("vec%0d q", i),        64'(q),        64'(tbl[i].eq));
            chk($sformatf("vec%0d q_vld", i),    64'(q_vld),    64'(tbl[i].eqv));
            chk($sformatf("vec%0d taps", i),     64'(taps),     64'(tbl[i].et));
            chk($sformatf("vec%0d taps_vld", i), 64'(taps_vld), 64'(tbl[i].etv));
`ifdef DFF_PIPE_OCCUPANCY_EN
            chk($sformatf("vec%0d occ", i),      64'(occ),      64'($countones(tbl[i].etv)));
`endif
        end

        // Main DUT idles (hold) while the DEPTH=1 instance is exercised.
        rst = 0; clr = 0; en = 0; set_mask = '0; vld_in = 0;

        rst1 = 1; en1 = 1; d1 = 0; vld1 = 1; tick();
        chk("d1 reset q", 64'(q1), 64'(1)); chk("d1 reset qv", 64'(qv1), 64'(0));
        rst1 = 0; en1 = 1; d1 = 0; vld1 = 1; mask1 = 0; tick();
        chk("d1 load0 q", 64'(q1), 64'(0)); chk("d1 load0 qv", 64'(qv1), 64'(1));
        en1 = 0; mask1 = 1; vld1 = 0; tick();
        chk("d1 set q", 64'(q1), 64'(1)); chk("d1 set qv", 64'(qv1), 64'(1));
        en1 = 1; d1 = 0; mask1 = 0; vld1 = 0; tick();
        chk("d1 adv q", 64'(q1), 64'(0)); chk("d1 adv qv", 64'(qv1), 64'(0));
        clr1 = 1; en1 = 1; d1 = 0; vld1 = 1; tick();
        chk("d1 clr q", 64'(q1), 64'(1)); chk("d1 clr qv", 64'(qv1), 64'(0));
        clr1 = 0; en1 = 1; d1 = 0; tick();
        chk("d1 reload q", 64'(q1), 64'(0));
        rst1 = 1; tick();
        chk("d1 rst q", 64'(q1), 64'(1)); chk("d1 taps", 64'(taps1), 64'(1));
        chk("d1 tv", 64'(tv1), 64'(0));
        rst1 = 0;
        chk_model("idle");

        // Randomized traffic against the queue model.
        for (int n = 0; n < 400; n++) begin
            rst      = ($urandom_range(0, 59) == 0);
            clr      = ($urandom_range(0, 24) == 0);
            en       = ($urandom_range(0, 9) < 6);
            d        = 8'($urandom);
            vld_in   = 1'($urandom);
            set_mask = 8'($urandom & $urandom & $urandom);
            tick();
            chk_model($sformatf("rnd%0d", n));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
